// File: rtl/des_pkg.sv
// Shared DES definitions: permutation tables, S-boxes, shift schedules and the
// bit-level helpers used by both the pipelined encryptor and the iterative decryptor.
// Bit order: FIPS bit 1 is bus bit [63]. Every table entry is a 1-based FIPS index.
package des_pkg;

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                               64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30,
                               37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T  [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                               16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T  [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

  // S-box entry index is {row, column} = {b1, b6, b2..b5} of the 6-bit group.
  localparam int SBOX_T [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // Left rotations before encrypt rounds 1..16; right rotations before decrypt rounds 2..16.
  localparam int SHIFT_ENC [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SHIFT_DEC [15] = '{1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction

  // Parity bits (8, 16, ..., 64) are never referenced by PC1 and so drop out here.
  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] sbox_sub(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  g;
    y = '0;
    for (int b = 0; b < 8; b++) begin
      g = x[47-6*b -: 6];
      y[31-4*b -: 4] = 4'(SBOX_T[b][{g[5], g[0], g[4:1]}]);
    end
    return y;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] amt);
    case (amt)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  // Rotation applied after 0-based decrypt round idx; none after the last round.
  function automatic logic [1:0] dec_shift(input logic [4:0] idx);
    return (idx < 5'd15) ? 2'(SHIFT_DEC[idx[3:0]]) : 2'd0;
  endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round: L' = R, R' = L ^ f(R, K).
// Shared by the encryptor and the decryptor; key order is the caller's concern.
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l_i,
  input  logic [31:0] r_i,
  input  logic [47:0] k_i,
  output logic [31:0] l_o,
  output logic [31:0] r_o
);

  assign l_o = r_i;
  assign r_o = l_i ^ p_perm(sbox_sub(e_expand(r_i) ^ k_i));

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryptor. Accepts one ciphertext/key pair, runs the 16 rounds
// with subkeys K16..K1 at ROUNDS_PER_CYCLE rounds per clock (1, 2 or 4), then
// presents the plaintext until the downstream side takes it.
module des_decrypt_iter
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [63:0] key,
  input  logic [63:0] ciphertext,
  input  logic        iv,
  output logic        ir,
  output logic [63:0] plaintext,
  output logic        ov,
  input  logic        or_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [4:0] CNT_STEP = 5'(ROUNDS_PER_CYCLE);
  localparam logic [4:0] CNT_DONE = 5'd16;
  localparam int         LAST     = ROUNDS_PER_CYCLE - 1;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [63:0] pt_q, pt_d;

  // Round chain: C/D already hold the key state for round cnt_q, so the first
  // stage uses them directly and each stage rotates right ready for the next.
  for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
    logic [31:0] l_in, r_in, l_out, r_out;
    logic [27:0] c_in, d_in, c_out, d_out;
    logic [1:0]  shift;

    if (j == 0) begin : g_first
      assign l_in = l_q;
      assign r_in = r_q;
      assign c_in = c_q;
      assign d_in = d_q;
    end else begin : g_next
      assign l_in = g_round[j-1].l_out;
      assign r_in = g_round[j-1].r_out;
      assign c_in = g_round[j-1].c_out;
      assign d_in = g_round[j-1].d_out;
    end

    des_round u_round (
      .l_i (l_in),
      .r_i (r_in),
      .k_i (pc2_perm({c_in, d_in})),
      .l_o (l_out),
      .r_o (r_out)
    );

    assign shift = dec_shift(cnt_q + 5'(j));
    assign c_out = rotr28(c_in, shift);
    assign d_out = rotr28(d_in, shift);
  end

  assign ir        = reset_n && (state_q == S_IDLE);
  assign ov        = (state_q == S_HOLD);
  assign plaintext = pt_q;

  // Next-state logic: load on accept, iterate rounds, publish and hold the result.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    pt_d    = pt_q;
    case (state_q)
      S_IDLE: begin
        if (iv && ir) begin
          {l_d, r_d} = ip_perm(ciphertext);
          {c_d, d_d} = pc1_perm(key);
          cnt_d      = '0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        l_d   = g_round[LAST].l_out;
        r_d   = g_round[LAST].r_out;
        c_d   = g_round[LAST].c_out;
        d_d   = g_round[LAST].d_out;
        cnt_d = cnt_q + CNT_STEP;
        if (cnt_d == CNT_DONE) begin
          // Halves are swapped back before the final permutation.
          pt_d    = fp_perm({g_round[LAST].r_out, g_round[LAST].l_out});
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (or_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; an asynchronous reset abandons any transaction in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      pt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      pt_q    <= pt_d;
    end
  end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Self-checking bench for des_decrypt_iter at 1, 2 and 4 rounds per cycle.
// Expected plaintexts come from known DES vectors and from a loopback through a
// behavioural DES encryptor written directly from the standard algorithm.
module tb_des_decrypt_iter;

  localparam int M_IP [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                               64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int M_FP [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30,
                               37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int M_E  [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                               16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int M_P  [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int M_PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int M_PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int M_SHL [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int M_S [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  localparam int          LAT [3]    = '{16, 8, 4};
  localparam logic [63:0] PARITY_MSK = 64'h0101010101010101;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [63:0] key, ciphertext;
  logic        or_i;
  logic        iv [3];
  logic        ir [3];
  logic        ov [3];
  logic [63:0] pt [3];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  des_decrypt_iter #(.ROUNDS_PER_CYCLE(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .key(key), .ciphertext(ciphertext), .iv(iv[0]),
    .ir(ir[0]), .plaintext(pt[0]), .ov(ov[0]), .or_i(or_i));
  des_decrypt_iter #(.ROUNDS_PER_CYCLE(2)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .key(key), .ciphertext(ciphertext), .iv(iv[1]),
    .ir(ir[1]), .plaintext(pt[1]), .ov(ov[1]), .or_i(or_i));
  des_decrypt_iter #(.ROUNDS_PER_CYCLE(4)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .key(key), .ciphertext(ciphertext), .iv(iv[2]),
    .ir(ir[2]), .plaintext(pt[2]), .ov(ov[2]), .or_i(or_i));

  // Textbook DES encryption (forward key schedule with left rotations K1..K16).
  function automatic logic [63:0] des_enc(input logic [63:0] p_in, input logic [63:0] k);
    logic [63:0] blk, res;
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [31:0] l, r, tmp, s_out, f;
    logic [47:0] er, sk, x;
    logic [5:0]  six;
    int          row, col;
    for (int i = 0; i < 64; i++) blk[63-i] = p_in[64-M_IP[i]];
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-M_PC1[i]];
    c = cd[55:28];
    d = cd[27:0];
    l = blk[63:32];
    r = blk[31:0];
    for (int n = 0; n < 16; n++) begin
      for (int s = 0; s < M_SHL[n]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) sk[47-i] = cd[56-M_PC2[i]];
      for (int i = 0; i < 48; i++) er[47-i] = r[32-M_E[i]];
      x = er ^ sk;
      for (int b = 0; b < 8; b++) begin
        six = x[47-6*b -: 6];
        row = 2 * int'(six[5]) + int'(six[0]);
        col = int'(six[4:1]);
        s_out[31-4*b -: 4] = 4'(M_S[b][row*16 + col]);
      end
      for (int i = 0; i < 32; i++) f[31-i] = s_out[32-M_P[i]];
      tmp = r;
      r   = l ^ f;
      l   = tmp;
    end
    blk = {r, l};
    for (int i = 0; i < 64; i++) res[63-i] = blk[64-M_FP[i]];
    return res;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; waits for ir, presents one transaction for one edge, then scrambles inputs.
  task automatic start(input int d, input logic [63:0] k, input logic [63:0] c, input string tag);
    int waited = 0;
    while (ir[d] !== 1'b1 && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    check({tag, "_ir_wait"}, 64'(ir[d]), 64'd1);
    key        = k;
    ciphertext = c;
    iv[d]      = 1'b1;
    @(posedge clock);
    @(negedge clock);
    iv[d]      = 1'b0;
    key        = {$urandom, $urandom};
    ciphertext = {$urandom, $urandom};
  endtask

  // Counts edges from the accept edge until ov, then checks latency and result.
  task automatic finish(input int d, input logic [63:0] exp, input string tag);
    int lat = 0;
    while (ov[d] !== 1'b1 && lat < 40) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    check({tag, "_latency"}, 64'(lat), 64'(LAT[d]));
    check({tag, "_pt"}, pt[d], exp);
  endtask

  // With or_i high, the result is taken on the next edge and the block is ready again.
  task automatic drain(input int d, input string tag);
    @(posedge clock);
    @(negedge clock);
    check({tag, "_ov_drop"}, 64'(ov[d]), 64'd0);
    check({tag, "_ir_back"}, 64'(ir[d]), 64'd1);
  endtask

  task automatic watch_no_ov(input string tag);
    int ov_seen = 0;
    repeat (25) begin
      @(posedge clock);
      @(negedge clock);
      if (ov[0] === 1'b1) ov_seen++;
    end
    check(tag, 64'(ov_seen), 64'd0);
  endtask

  initial begin
    logic [63:0] p, k, c, p2, k2, c2;

    reset_n    = 1'b1;
    key        = '0;
    ciphertext = '0;
    or_i       = 1'b1;
    for (int i = 0; i < 3; i++) iv[i] = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);

    // Reset state.
    check("rst_ov",  64'(ov[0]), 64'd0);
    check("rst_ir",  64'(ir[0]), 64'd0);
    check("rst_pt",  pt[0], 64'd0);
    check("rst_ov4", 64'(ov[2]), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("rel_ir", 64'(ir[0]), 64'd1);

    // Known-answer vectors.
    start(0, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, "fips");
    check("fips_busy_ir", 64'(ir[0]), 64'd0);
    finish(0, 64'h0123456789ABCDEF, "fips");
    drain(0, "fips");
    for (int d = 0; d < 3; d++) begin
      start(d, 64'h0E329232EA6D0D73, 64'h0, $sformatf("kat_d%0d", d));
      finish(d, 64'h8787878787878787, $sformatf("kat_d%0d", d));
      drain(d, $sformatf("kat_d%0d", d));
    end

    // Output back-pressure: result held, ir low, stray iv ignored.
    or_i = 1'b0;
    p = {$urandom, $urandom};
    k = {$urandom, $urandom};
    c = des_enc(p, k);
    start(0, k, c, "hold");
    finish(0, p, "hold");
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        iv[0]      = 1'b1;
        ciphertext = {$urandom, $urandom};
      end
      @(posedge clock);
      @(negedge clock);
      iv[0] = 1'b0;
      check("hold_ov", 64'(ov[0]), 64'd1);
      check("hold_pt", pt[0], p);
      check("hold_ir", 64'(ir[0]), 64'd0);
    end

    // iv and or_i together in HOLD: only the output completes; input taken next cycle.
    p2 = {$urandom, $urandom};
    k2 = {$urandom, $urandom};
    c2 = des_enc(p2, k2);
    or_i       = 1'b1;
    iv[0]      = 1'b1;
    key        = k2;
    ciphertext = c2;
    @(posedge clock);
    @(negedge clock);
    check("both_ov", 64'(ov[0]), 64'd0);
    check("both_ir", 64'(ir[0]), 64'd1);
    check("both_pt_kept", pt[0], p);
    @(posedge clock);
    @(negedge clock);
    iv[0]      = 1'b0;
    key        = {$urandom, $urandom};
    ciphertext = {$urandom, $urandom};
    check("both_accepted", 64'(ir[0]), 64'd0);
    finish(0, p2, "both_next");
    drain(0, "both_next");

    // Reset at round 7.
    p = {$urandom, $urandom};
    k = {$urandom, $urandom};
    start(0, k, des_enc(p, k), "rst_run");
    repeat (6) begin
      @(posedge clock);
      @(negedge clock);
    end
    #2 reset_n = 1'b0;
    #1;
    check("rst_run_ov", 64'(ov[0]), 64'd0);
    check("rst_run_pt", pt[0], 64'd0);
    check("rst_run_ir", 64'(ir[0]), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    watch_no_ov("rst_run_no_ov");
    p = {$urandom, $urandom};
    k = {$urandom, $urandom};
    start(0, k, des_enc(p, k), "after_rst");
    finish(0, p, "after_rst");
    drain(0, "after_rst");

    // Reset while holding a result.
    or_i = 1'b0;
    p = {$urandom, $urandom};
    k = {$urandom, $urandom};
    start(0, k, des_enc(p, k), "rst_hold");
    finish(0, p, "rst_hold");
    #2 reset_n = 1'b0;
    #1;
    check("rst_hold_ov", 64'(ov[0]), 64'd0);
    check("rst_hold_pt", pt[0], 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    or_i    = 1'b1;
    watch_no_ov("rst_hold_no_ov");

    // Loopback through the reference encryptor, with random parity-bit flips on every 10th key.
    for (int n = 0; n < 1000; n++) begin
      p = {$urandom, $urandom};
      k = {$urandom, $urandom};
      c = des_enc(p, k);
      start(0, k, c, "loop");
      finish(0, p, "loop");
      if (n % 10 == 0) begin
        start(0, k ^ ({$urandom, $urandom} & PARITY_MSK) ^ 64'h0100000000000000, c, "parity");
        finish(0, p, "parity");
      end
    end
    for (int d = 1; d < 3; d++) begin
      for (int n = 0; n < 50; n++) begin
        p = {$urandom, $urandom};
        k = {$urandom, $urandom};
        start(d, k, des_enc(p, k), $sformatf("loop_d%0d", d));
        finish(d, p, $sformatf("loop_d%0d", d));
      end
    end

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
